bound_flasher_param: RTL and testbench

BOUND_FLASHER_PARAM -- requirements
Module: bound_flasher_param

---
 rtl/bound_flasher_param.sv | 169 ++++++++++++++++
 tb/tb_bound_flasher_param.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bound_flasher_param.sv
// Bound flasher: a thermometer LED bar that climbs and falls between two bounds,
// then to full scale, with optional kickback on flick and a prescaled step rate.
module bound_flasher_param #(
   parameter int N   = 16,
   parameter int B1  = 5,
   parameter int B2  = 10,
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flick,
   input  logic         en,
   input  logic         abort,
   input  logic         repeat_mode,  // "repeat" is a reserved word
   output logic [N-1:0] led,
   output logic         busy,
   output logic [2:0]   phase,
   output logic         done
);

   localparam int LW = $clog2(N + 1);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [LW-1:0] L_ZERO = '0;
   localparam logic [LW-1:0] L_ONE  = LW'(1);
   localparam logic [LW-1:0] L_B1   = LW'(B1);
   localparam logic [LW-1:0] L_B2   = LW'(B2);
   localparam logic [LW-1:0] L_N    = LW'(N);
   localparam logic [PW-1:0] P_MAX  = PW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      UP1  = 3'd1,
      DN1  = 3'd2,
      UP2  = 3'd3,
      DN2  = 3'd4,
      UP3  = 3'd5,
      DN3  = 3'd6
   } state_t;

   state_t          state;
   logic [LW-1:0]   lit;
   logic [PW-1:0]   presc;
   logic            tick;
   logic            kick_pt;
   logic            state_bad;

   function automatic logic [LW-1:0] sat_inc(input logic [LW-1:0] l);
      return (l >= L_N) ? L_N : l + L_ONE;
   endfunction

   function automatic logic [LW-1:0] sat_dec(input logic [LW-1:0] l);
      return (l == L_ZERO) ? L_ZERO : l - L_ONE;
   endfunction

   assign tick      = en && (presc == P_MAX);
   assign kick_pt   = (lit == L_B1) || (lit == L_B2);
   assign state_bad = (state > DN3) || (lit > L_N);

   // Prescaler holds its count while en is low so no step time is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc <= '0;
      end else if (abort) begin
         presc <= '0;
      end else if (en) begin
         presc <= (presc == P_MAX) ? '0 : presc + PW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lit   <= L_ZERO;
         done  <= 1'b0;
      end else if (abort || state_bad) begin
         state <= IDLE;
         lit   <= L_ZERO;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (flick) begin
                     state <= UP1;
                     lit   <= L_ONE;
                  end else begin
                     lit <= L_ZERO;
                  end
               end
               UP1: begin
                  if (lit == L_B1) begin
                     state <= DN1;
                     lit   <= sat_dec(lit);
                  end else begin
                     lit <= sat_inc(lit);
                  end
               end
               DN1: begin
                  if (lit == L_ZERO) begin
                     state <= UP2;
                     lit   <= L_ONE;
                  end else begin
                     lit <= sat_dec(lit);
                  end
               end
               // Kickback outranks the B2 reversal when both fall on one tick.
               UP2: begin
                  if (flick && kick_pt) begin
                     state <= DN1;
                     lit   <= sat_dec(lit);
                  end else if (lit == L_B2) begin
                     state <= DN2;
                     lit   <= sat_dec(lit);
                  end else begin
                     lit <= sat_inc(lit);
                  end
               end
               DN2: begin
                  if (lit == L_B1) begin
                     state <= UP3;
                     lit   <= L_B1 + L_ONE;
                  end else begin
                     lit <= sat_dec(lit);
                  end
               end
               UP3: begin
                  if (flick && kick_pt) begin
                     state <= DN2;
                     lit   <= sat_dec(lit);
                  end else if (lit == L_N) begin
                     state <= DN3;
                     lit   <= L_N - L_ONE;
                  end else begin
                     lit <= sat_inc(lit);
                  end
               end
               DN3: begin
                  if (lit == L_ZERO) begin
                     done <= 1'b1;
                     if (repeat_mode) begin
                        state <= UP1;
                        lit   <= L_ONE;
                     end else begin
                        state <= IDLE;
                        lit   <= L_ZERO;
                     end
                  end else begin
                     lit <= sat_dec(lit);
                  end
               end
               default: begin
                  state <= IDLE;
                  lit   <= L_ZERO;
               end
            endcase
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_led
      assign led[g] = (lit > LW'(g));
   end

   assign busy  = (state != IDLE);
   assign phase = state;

endmodule

// File: tb/tb_bound_flasher_param.sv
// Scoreboard bench for bound_flasher_param: a DIV=1 instance for the step sequence
// and a DIV=4 instance for prescaler and enable-freeze timing.
module tb_bound_flasher_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        fa, ea, aa, ra;
   logic        fb, eb, ab, rb;
   logic [15:0] led_a, led_b;
   logic        busy_a, busy_b, done_a, done_b;
   logic [2:0]  ph_a, ph_b;

   bound_flasher_param #(.N(16), .B1(5), .B2(10), .DIV(1)) u_dut (
      .clk(clk), .rst(rst), .flick(fa), .en(ea), .abort(aa), .repeat_mode(ra),
      .led(led_a), .busy(busy_a), .phase(ph_a), .done(done_a)
   );

   bound_flasher_param #(.N(16), .B1(5), .B2(10), .DIV(4)) u_div4 (
      .clk(clk), .rst(rst), .flick(fb), .en(eb), .abort(ab), .repeat_mode(rb),
      .led(led_b), .busy(busy_b), .phase(ph_b), .done(done_b)
   );

   typedef struct {
      bit          sel;
      logic [15:0] led;
      logic [2:0]  ph;
      logic        dn;
      int          tag;
   } want_t;

   want_t sb_q[$];
   int    n_chk   = 0;
   int    n_pass  = 0;
   int    step_no = 0;

   task automatic check(input string nm, input int tag, input logic [31:0] act,
                        input logic [31:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, tag, act, want);
   endtask

   function automatic logic [15:0] th(input int k);
      logic [31:0] t;
      t = (32'd1 << k) - 32'd1;
      return t[15:0];
   endfunction

   // One clock of stimulus; the expected outputs after the coming edge go on the queue.
   task automatic step(input bit sel, input logic f, input logic e, input logic a,
                       input logic r, input int k, input logic [2:0] ph, input logic dn);
      want_t x;
      @(negedge clk);
      if (!sel) begin
         fa = f; ea = e; aa = a; ra = r;
      end else begin
         fb = f; eb = e; ab = a; rb = r;
      end
      step_no++;
      x.sel = sel; x.led = th(k); x.ph = ph; x.dn = dn; x.tag = step_no;
      sb_q.push_back(x);
   endtask

   task automatic a_step(input logic f, input int k, input logic [2:0] ph, input logic dn);
      step(1'b0, f, 1'b1, 1'b0, ra, k, ph, dn);
   endtask

   task automatic b_step(input logic f, input logic e, input int k, input logic [2:0] ph);
      step(1'b1, f, e, 1'b0, 1'b0, k, ph, 1'b0);
   endtask

   // IDLE -> UP1 1..5 -> DN1 4..0 -> UP2 1..10 (flick only on the first tick)
   task automatic a_to_up2_top();
      a_step(1'b1, 1, 3'd1, 1'b0);
      for (int k = 2; k <= 5; k++) a_step(1'b0, k, 3'd1, 1'b0);
      for (int k = 4; k >= 0; k--) a_step(1'b0, k, 3'd2, 1'b0);
      for (int k = 1; k <= 10; k++) a_step(1'b0, k, 3'd3, 1'b0);
   endtask

   task automatic a_dn2_up3(input int kmax);
      for (int k = 9; k >= 5; k--) a_step(1'b0, k, 3'd4, 1'b0);
      for (int k = 6; k <= kmax; k++) a_step(1'b0, k, 3'd5, 1'b0);
   endtask

   task automatic a_dn3();
      for (int k = 15; k >= 0; k--) a_step(1'b0, k, 3'd6, 1'b0);
   endtask

   task automatic check_idle_now(input string nm);
      check({nm, "_led_a"},  0, 32'(led_a),  32'h0);
      check({nm, "_ph_a"},   0, 32'(ph_a),   32'h0);
      check({nm, "_busy_a"}, 0, 32'(busy_a), 32'h0);
      check({nm, "_done_a"}, 0, 32'(done_a), 32'h0);
      check({nm, "_led_b"},  0, 32'(led_b),  32'h0);
      check({nm, "_ph_b"},   0, 32'(ph_b),   32'h0);
   endtask

   // Monitor: one expected entry per driven clock, compared just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            want_t x;
            x = sb_q.pop_front();
            if (!x.sel) begin
               check("led_a",  x.tag, 32'(led_a),  32'(x.led));
               check("ph_a",   x.tag, 32'(ph_a),   32'(x.ph));
               check("busy_a", x.tag, 32'(busy_a), 32'(x.ph != 3'd0));
               check("done_a", x.tag, 32'(done_a), 32'(x.dn));
            end else begin
               check("led_b",  x.tag, 32'(led_b),  32'(x.led));
               check("ph_b",   x.tag, 32'(ph_b),   32'(x.ph));
               check("busy_b", x.tag, 32'(busy_b), 32'(x.ph != 3'd0));
               check("done_b", x.tag, 32'(done_b), 32'(x.dn));
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      fa = 1'b0; ea = 1'b1; aa = 1'b0; ra = 1'b0;
      fb = 1'b0; eb = 1'b1; ab = 1'b0; rb = 1'b0;
      #7;
      check_idle_now("reset");
      @(negedge clk);
      rst = 1'b0;

      // Full single-flick sequence ending with a one-cycle done pulse
      a_to_up2_top();
      a_dn2_up3(16);
      a_dn3();
      a_step(1'b0, 0, 3'd0, 1'b1);
      a_step(1'b0, 0, 3'd0, 1'b0);

      // Kickback at the B2 top of UP2, back down, then UP2 restarts at one LED
      a_to_up2_top();
      a_step(1'b1, 9, 3'd2, 1'b0);
      for (int k = 8; k >= 0; k--) a_step(1'b0, k, 3'd2, 1'b0);
      for (int k = 1; k <= 10; k++) a_step(1'b0, k, 3'd3, 1'b0);
      for (int k = 9; k >= 7; k--) a_step(1'b0, k, 3'd4, 1'b0);
      // Abort with en low mid-DN2
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 3'd0, 1'b0);
      a_step(1'b0, 0, 3'd0, 1'b0);

      // Repeat mode: DN3 completion goes straight back into UP1
      ra = 1'b1;
      a_to_up2_top();
      a_dn2_up3(16);
      a_dn3();
      a_step(1'b0, 1, 3'd1, 1'b1);
      a_step(1'b0, 2, 3'd1, 1'b0);
      a_step(1'b0, 3, 3'd1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 3'd0, 1'b0);
      ra = 1'b0;
      a_step(1'b0, 0, 3'd0, 1'b0);

      // Asynchronous reset between edges while UP3 shows 0x0FFF
      a_to_up2_top();
      a_dn2_up3(12);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_idle_now("async_rst");
      @(negedge clk);
      rst = 1'b0;
      a_step(1'b0, 0, 3'd0, 1'b0);
      a_step(1'b0, 0, 3'd0, 1'b0);

      // DIV=4: a step every 4 clocks, en low for 3 clocks shifts the next step by 3
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3'd0, 1'b0);
      for (int i = 0; i < 3; i++) b_step(1'b1, 1'b1, 0, 3'd0);
      b_step(1'b1, 1'b1, 1, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1, 1, 3'd1);
      b_step(1'b0, 1'b1, 2, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1, 2, 3'd1);
      b_step(1'b0, 1'b1, 3, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b0, 3, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1, 3, 3'd1);
      b_step(1'b0, 1'b1, 4, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1, 4, 3'd1);
      b_step(1'b0, 1'b1, 5, 3'd1);
      for (int i = 0; i < 3; i++) b_step(1'b0, 1'b1, 5, 3'd1);
      b_step(1'b0, 1'b1, 4, 3'd2);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 3'd0, 1'b0);

      @(posedge clk);
      #2;
      check("scoreboard_drain", 0, 32'(sb_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
